// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter between fetch (port 0) and data/trace (port 1) in front of the cache CPU port.
// Latency: request sampled in IDLE -> cache_valid next cycle; ack one cycle after cache_ready or watchdog expiry.
// Backpressure: one transaction in flight; requesters hold valid until ack, are ignored while BUSY/DONE.
module cache_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_rw,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_rw,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              cache_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_rw,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic              cache_ready,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              grant
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic              cache_rw_q, cache_rw_d;
    logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              win;

    // last_grant resets to 1 so port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_rw_q    <= 1'b0;
            cache_wdata_q <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_rw_q    <= cache_rw_d;
            cache_wdata_q <= cache_wdata_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_rw_d    = cache_rw_q;
        cache_wdata_d = cache_wdata_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        err0_d        = err0_q;
        err1_d        = err1_q;
        wd_cnt_d      = wd_cnt_q;
        win           = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    win           = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    cache_addr_d  = win ? req1_addr  : req0_addr;
                    cache_rw_d    = win ? req1_rw    : req0_rw;
                    cache_wdata_d = win ? req1_wdata : req0_wdata;
                    cache_valid_d = 1'b1;
                    grant_d       = win;
                    last_grant_d  = win;
                    wd_cnt_d      = '0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (wd_cnt_q != WD_LAST) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                // A ready on the final watchdog cycle still counts as a normal completion.
                if (cache_ready || (wd_cnt_q == WD_LAST)) begin
                    cache_valid_d = 1'b0;
                    state_d       = DONE;
                    if (grant_q) begin
                        ack1_d   = 1'b1;
                        rdata1_d = cache_ready ? cache_rdata : '0;
                        err1_d   = ~cache_ready;
                    end else begin
                        ack0_d   = 1'b1;
                        rdata0_d = cache_ready ? cache_rdata : '0;
                        err0_d   = ~cache_ready;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign req0_err    = err0_q;
    assign req1_err    = err1_q;
    assign cache_valid = cache_valid_q;
    assign cache_addr  = cache_addr_q;
    assign cache_rw    = cache_rw_q;
    assign cache_wdata = cache_wdata_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed transactions, expected acks queued and checked by a monitor.
module tb_cache_req_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic        req0_rw = 1'b0, req1_rw = 1'b0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ack, req1_ack, req0_err, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        cache_valid, cache_rw, grant;
    logic [31:0] cache_addr, cache_wdata;
    logic        cache_ready = 1'b0;
    logic [31:0] cache_rdata = '0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    cache_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_rw(req0_rw), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_rw(req1_rw), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_rw(cache_rw),
        .cache_wdata(cache_wdata), .cache_ready(cache_ready), .cache_rdata(cache_rdata),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cache_valid"}, 32'(cache_valid), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_cache_addr"}, cache_addr, 0);
        chk({tag, "_cache_rw"}, 32'(cache_rw), 0);
        chk({tag, "_cache_wdata"}, cache_wdata, 0);
        chk({tag, "_acks"}, {30'b0, req1_ack, req0_ack}, 0);
        chk({tag, "_rdata0"}, req0_rdata, 0);
        chk({tag, "_rdata1"}, req1_rdata, 0);
        chk({tag, "_errs"}, {30'b0, req1_err, req0_err}, 0);
    endtask

    // Called #1 after a posedge with the DUT idle; n is the cycle cache_ready is driven (0 = never).
    task automatic txn(input logic port, input logic [31:0] addr, input logic rw,
                       input logic [31:0] wdata, input int n, input logic [31:0] rd,
                       input bit mutate, input bit keep);
        exp_t e;
        int   last;
        if (port) begin
            req1_valid = 1'b1; req1_addr = addr; req1_rw = rw; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_addr = addr; req0_rw = rw; req0_wdata = wdata;
        end
        e.port  = port;
        e.rdata = (n == 0) ? 32'h0 : rd;
        e.err   = (n == 0);
        exp_q.push_back(e);
        last = (n == 0) ? TO : n;
        @(posedge clk); #1;
        chk("grant", 32'(grant), 32'(port));
        for (int c = 1; c <= last; c++) begin
            chk("busy_valid", 32'(cache_valid), 1);
            chk("busy_addr", cache_addr, addr);
            chk("busy_rw", 32'(cache_rw), 32'(rw));
            chk("busy_wdata", cache_wdata, wdata);
            if (mutate) begin
                if (port) begin req1_addr = ~addr; req1_wdata = ~wdata; end
                else begin req0_addr = ~addr; req0_wdata = ~wdata; end
            end
            cache_ready = (c == n);
            cache_rdata = (c == n) ? rd : (32'hBAD0_0000 | 32'(c));
            @(posedge clk); #1;
            cache_ready = 1'b0;
        end
        chk("ack_cycle", 32'(port ? req1_ack : req0_ack), 1);
        chk("valid_drop", 32'(cache_valid), 0);
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (req0_ack || req1_ack)) begin
            exp_t e;
            checks++;
            if (req0_ack && req1_ack) begin
                errors++;
                $display("FAIL ack_both: ack0=%b ack1=%b, required one-hot", req0_ack, req1_ack);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ack0=%b ack1=%b with none outstanding", req0_ack, req1_ack);
            end else begin
                e = exp_q.pop_front();
                if (req1_ack) begin
                    if (e.port !== 1'b1 || req1_rdata !== e.rdata || req1_err !== e.err) begin
                        errors++;
                        $display("FAIL ack_resp: got port=1 rdata=%h err=%b, expected port=%0d rdata=%h err=%b",
                                 req1_rdata, req1_err, e.port, e.rdata, e.err);
                    end
                end else begin
                    if (e.port !== 1'b0 || req0_rdata !== e.rdata || req0_err !== e.err) begin
                        errors++;
                        $display("FAIL ack_resp: got port=0 rdata=%h err=%b, expected port=%0d rdata=%h err=%b",
                                 req0_rdata, req0_err, e.port, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL sim_timeout: simulation still running at %0t, limit 200000", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("after_reset");

        // Single read, ready 2 cycles after cache_valid rises.
        txn(1'b0, 32'h0000_0040, 1'b0, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Write on port 1 with requester fields changing mid-transaction.
        txn(1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4, 32'h0000_A5A5, 1'b1, 1'b0);

        // Watchdog expiry, then a late ready must be dropped.
        txn(1'b0, 32'h0000_0080, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        cache_ready = 1'b1;
        cache_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        cache_ready = 1'b0;
        chk("late_rdy_rdata0", req0_rdata, 32'h0);
        chk("late_rdy_err0", 32'(req0_err), 1);
        chk("late_rdy_acks", {30'b0, req1_ack, req0_ack}, 0);
        chk("late_rdy_valid", 32'(cache_valid), 0);
        chk("late_rdy_rdata1", req1_rdata, 32'h0000_A5A5);
        txn(1'b0, 32'h0000_0084, 1'b0, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Ready coincides with the last watchdog cycle.
        txn(1'b1, 32'h0000_0200, 1'b0, 32'h0, TO, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Continuous tie: grants alternate starting with port 0.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            txn(1'(i % 2), 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 2, 32'h7700_0000 + 32'(i), 1'b0, (i != 7));
        end

        // Reset during BUSY: outputs clear asynchronously, no ack, port 0 wins the next tie.
        req0_valid = 1'b1; req0_addr = 32'h0000_0300; req0_rw = 1'b1; req0_wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_busy_reset");
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_idle", 32'(cache_valid), 0);
        req1_valid = 1'b1; req1_addr = 32'h0000_0400;
        txn(1'b0, 32'h0000_0304, 1'b0, 32'h0, 2, 32'h0123_4567, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: %0d outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
